// File: rtl/mux_operand_sequencer.sv
// Operand feeder for the 4:1 matrix-multiplier mux: loads four words over valid/ready,
// then sweeps the mux select 0..3 REPEAT times under downstream backpressure.
module mux_operand_sequencer #(
  parameter int DATA_W = 16,
  parameter int REPEAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              abort,
  output logic [DATA_W-1:0] word_0,
  output logic [DATA_W-1:0] word_1,
  output logic [DATA_W-1:0] word_2,
  output logic [DATA_W-1:0] word_3,
  output logic [1:0]        select,
  output logic              sel_valid,
  input  logic              out_ready,
  output logic              mux_clear,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_PASS = 8'(REPEAT - 1);

  state_t            state_q, state_d;
  logic [1:0]        load_cnt_q, load_cnt_d;
  logic [1:0]        select_q, select_d;
  logic [7:0]        pass_cnt_q, pass_cnt_d;
  logic              sel_valid_q, sel_valid_d;
  logic              done_q, done_d;
  logic              mux_clear_q, mux_clear_d;
  logic [DATA_W-1:0] word_q [4];
  logic [DATA_W-1:0] word_d [4];
  logic              word_we;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    select_d   = select_q;
    pass_cnt_d = pass_cnt_q;
    word_we    = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          word_we    = 1'b1;
          load_cnt_d = load_cnt_q + 2'd1;
          if (load_cnt_q == 2'd3) begin
            state_d    = ST_STREAM;
            select_d   = 2'd0;
            pass_cnt_d = 8'd0;
          end
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          select_d = select_q + 2'd1;
          if (select_q == 2'd3) begin
            if (pass_cnt_q == LAST_PASS) begin
              state_d    = ST_DONE;
              pass_cnt_d = 8'd0;
            end else begin
              pass_cnt_d = pass_cnt_q + 8'd1;
            end
          end
        end
      end
      ST_DONE: state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase

    // abort wins over any coincident handshake, which is dropped entirely
    if (abort) begin
      state_d    = ST_LOAD;
      load_cnt_d = 2'd0;
      select_d   = 2'd0;
      pass_cnt_d = 8'd0;
      word_we    = 1'b0;
    end

    sel_valid_d = (state_d == ST_STREAM);
    done_d      = (state_d == ST_DONE);
    mux_clear_d = (state_d != ST_STREAM);

    for (int i = 0; i < 4; i++) begin
      word_d[i] = word_q[i];
    end
    if (word_we) begin
      word_d[load_cnt_q] = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_LOAD;
      load_cnt_q  <= 2'd0;
      select_q    <= 2'd0;
      pass_cnt_q  <= 8'd0;
      sel_valid_q <= 1'b0;
      done_q      <= 1'b0;
      mux_clear_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      select_q    <= select_d;
      pass_cnt_q  <= pass_cnt_d;
      sel_valid_q <= sel_valid_d;
      done_q      <= done_d;
      mux_clear_q <= mux_clear_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          word_q[gi] <= '0;
        end else begin
          word_q[gi] <= word_d[gi];
        end
      end
    end
  endgenerate

  // reset gating keeps in_ready low while the bank is being cleared
  assign in_ready  = reset && (state_q == ST_LOAD);
  assign word_0    = word_q[0];
  assign word_1    = word_q[1];
  assign word_2    = word_q[2];
  assign word_3    = word_q[3];
  assign select    = select_q;
  assign sel_valid = sel_valid_q;
  assign done      = done_q;
  assign mux_clear = mux_clear_q;

endmodule

// File: tb/tb_mux_operand_sequencer.sv
// Self-checking bench: two sequencers (REPEAT=1 and REPEAT=3) share stimulus and are
// compared every cycle against a count-based reference model, plus directed vectors.
module tb_mux_operand_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        abort;
  logic        out_ready;

  logic        ir_o  [2];
  logic [15:0] w_o   [2][4];
  logic [1:0]  sel_o [2];
  logic        sv_o  [2];
  logic        clr_o [2];
  logic        dn_o  [2];

  int n_checks;
  int n_errors;

  // reference model: words, number of words loaded (4 = streaming), consumed count
  int          reps    [2];
  logic [15:0] m_words [2][4];
  int          m_nload [2];
  int          m_k     [2];
  logic        m_donec [2];

  mux_operand_sequencer #(.DATA_W(16), .REPEAT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_o[0]),
    .in_data(in_data), .abort(abort),
    .word_0(w_o[0][0]), .word_1(w_o[0][1]), .word_2(w_o[0][2]), .word_3(w_o[0][3]),
    .select(sel_o[0]), .sel_valid(sv_o[0]), .out_ready(out_ready),
    .mux_clear(clr_o[0]), .done(dn_o[0])
  );

  mux_operand_sequencer #(.DATA_W(16), .REPEAT(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_o[1]),
    .in_data(in_data), .abort(abort),
    .word_0(w_o[1][0]), .word_1(w_o[1][1]), .word_2(w_o[1][2]), .word_3(w_o[1][3]),
    .select(sel_o[1]), .sel_valid(sv_o[1]), .out_ready(out_ready),
    .mux_clear(clr_o[1]), .done(dn_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) m_words[d][i] = 16'h0;
      m_nload[d] = 0;
      m_k[d]     = 0;
      m_donec[d] = 1'b0;
    end
  endtask

  // one clock edge of the model, using the inputs currently driven
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        for (int i = 0; i < 4; i++) m_words[d][i] = 16'h0;
        m_nload[d] = 0; m_k[d] = 0; m_donec[d] = 1'b0;
      end else if (abort) begin
        m_nload[d] = 0; m_k[d] = 0; m_donec[d] = 1'b0;
      end else if (m_donec[d]) begin
        m_donec[d] = 1'b0;
      end else if (m_nload[d] < 4) begin
        if (in_valid) begin
          m_words[d][m_nload[d]] = in_data;
          m_nload[d]++;
          m_k[d] = 0;
        end
      end else if (out_ready) begin
        m_k[d]++;
        if (m_k[d] == 4 * reps[d]) begin
          m_nload[d] = 0; m_k[d] = 0; m_donec[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic streaming;
      streaming = (m_nload[d] == 4);
      for (int i = 0; i < 4; i++)
        compare($sformatf("dut%0d word_%0d", d, i), 32'(w_o[d][i]), 32'(m_words[d][i]));
      compare($sformatf("dut%0d select", d), 32'(sel_o[d]), 32'(m_k[d] % 4));
      compare($sformatf("dut%0d sel_valid", d), 32'(sv_o[d]), 32'(streaming));
      compare($sformatf("dut%0d done", d), 32'(dn_o[d]), 32'(m_donec[d]));
      compare($sformatf("dut%0d mux_clear", d), 32'(clr_o[d]), 32'(!streaming));
      compare($sformatf("dut%0d in_ready", d), 32'(ir_o[d]),
              32'(reset && !streaming && !m_donec[d]));
    end
  endtask

  task automatic apply(input logic iv, input logic [15:0] dat, input logic ab, input logic ordy);
    in_valid  = iv;
    in_data   = dat;
    abort     = ab;
    out_ready = ordy;
    #1;
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cycle(input logic iv, input logic [15:0] dat, input logic ab, input logic ordy);
    apply(iv, dat, ab, ordy);
    advance();
  endtask

  task automatic load4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] e);
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b1, c, 1'b0, 1'b0);
    cycle(1'b1, e, 1'b0, 1'b0);
  endtask

  // run with out_ready high until both sequencers are back in LOAD
  task automatic drain();
    int budget;
    budget = 0;
    while ((m_nload[0] == 4 || m_donec[0] || m_nload[1] == 4 || m_donec[1]) && budget < 60) begin
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      budget++;
    end
    compare("drain timeout", 32'(budget < 60), 32'd1);
  endtask

  task automatic async_reset_pulse();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] dat;
    logic        ordy;
    logic [1:0]  e_sel;
    logic        e_sv;
    logic        e_done;
    logic        e_ir;
    logic        e_clr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 16'h1111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 16'h2222, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 16'h3333, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 16'h4444, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 16'h0000, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 16'h0000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};

    n_checks = 0;
    n_errors = 0;
    reps[0] = 1;
    reps[1] = 3;
    reset = 1'b0; in_valid = 1'b0; in_data = 16'h0; abort = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // basic load and sweep, REPEAT=1 instance checked against the table
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].iv, vecs[i].dat, 1'b0, vecs[i].ordy);
      compare($sformatf("vec%0d select", i), 32'(sel_o[0]), 32'(vecs[i].e_sel));
      compare($sformatf("vec%0d sel_valid", i), 32'(sv_o[0]), 32'(vecs[i].e_sv));
      compare($sformatf("vec%0d done", i), 32'(dn_o[0]), 32'(vecs[i].e_done));
      compare($sformatf("vec%0d in_ready", i), 32'(ir_o[0]), 32'(vecs[i].e_ir));
      compare($sformatf("vec%0d mux_clear", i), 32'(clr_o[0]), 32'(vecs[i].e_clr));
      advance();
    end
    compare("vec word_0", 32'(w_o[0][0]), 32'h1111);
    compare("vec word_3", 32'(w_o[0][3]), 32'h4444);
    drain();

    // backpressure at select=2
    load4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 16'h0, 1'b0, 1'b0);
      compare("bp select", 32'(sel_o[0]), 32'd2);
      compare("bp sel_valid", 32'(sv_o[0]), 32'd1);
      advance();
    end
    drain();

    // REPEAT=3: twelve consuming handshakes then a single done
    load4(16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3);
    begin
      int consumed, dones, budget;
      consumed = 0; dones = 0; budget = 0;
      while (dones == 0 && budget < 40) begin
        apply(1'b0, 16'h0, 1'b0, 1'b1);
        if (sv_o[1]) begin
          compare("rep3 select seq", 32'(sel_o[1]), 32'(consumed % 4));
          consumed++;
        end
        if (dn_o[1]) dones++;
        advance();
        budget++;
      end
      compare("rep3 consumed", 32'(consumed), 32'd12);
      for (int i = 0; i < 3; i++) begin
        apply(1'b0, 16'h0, 1'b0, 1'b1);
        if (dn_o[1]) dones++;
        advance();
      end
      compare("rep3 done pulses", 32'(dones), 32'd1);
    end

    // in_valid held during STREAM must not disturb the operand bank
    load4(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 16'hDEAD, 1'b0, 1'b1);
      compare("dead in_ready", 32'(ir_o[0]), 32'd0);
      advance();
    end
    compare("dead word_0", 32'(w_o[0][0]), 32'h0101);
    compare("dead word_2", 32'(w_o[0][2]), 32'h0303);
    drain();

    // abort at select=1 together with out_ready
    load4(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    apply(1'b0, 16'h0, 1'b1, 1'b1);
    compare("abort pre select", 32'(sel_o[0]), 32'd1);
    advance();
    apply(1'b0, 16'h0, 1'b0, 1'b0);
    compare("abort select", 32'(sel_o[0]), 32'd0);
    compare("abort in_ready", 32'(ir_o[0]), 32'd1);
    compare("abort done", 32'(dn_o[0]), 32'd0);
    advance();
    load4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    drain();

    // async reset after two words of a load
    cycle(1'b1, 16'hAAAA, 1'b0, 1'b0);
    cycle(1'b1, 16'hBBBB, 1'b0, 1'b0);
    async_reset_pulse();
    compare("rst word_0", 32'(w_o[0][0]), 32'h0);
    load4(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    compare("rst reload word_0", 32'(w_o[0][0]), 32'h0A0A);
    compare("rst reload word_3", 32'(w_o[0][3]), 32'h0D0D);
    drain();

    // randomized traffic with occasional abort
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
